multi_current_sensor: RTL

Periodic SPI readout engine for up to NUM_CHANNELS read-only current-sense ADCs that share SCK and MISO, with one active-low select per channel. It generalises the single-channel readout in channel count, word/result width, SCK rate and clock phase, and adds enable, busy, per-channel valid strobes and overrun detection. It has its own bit-level SPI shifter, so it needs no external SPI master core. It sits between the board pins and the motor-control register file.

---
 rtl/multi_current_sensor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multi_current_sensor.sv
`default_nettype none
// ============================================================================
// Module  : multi_current_sensor
// Brief   : Periodic SPI readout of NUM_CHANNELS current-sense ADCs sharing SCK/MISO.
//           Optional per-channel IIR smoothing: define CURRENT_SENSOR_FILTER_EN.
// Rev     : 1.0  initial release
// ============================================================================
module multi_current_sensor #(
  parameter int CLK_FREQ_HZ    = 32_000_000,
  parameter int UPDATE_FREQ_HZ = 100,
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 15,
  parameter int SCK_DIV        = 5,
  parameter int CPHA           = 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic                                 miso_i,
  output logic                                 sck_o,
  output logic [NUM_CHANNELS-1:0]              ss_n_o,
  output logic [NUM_CHANNELS*RESULT_WIDTH-1:0] current_o,
  output logic [NUM_CHANNELS-1:0]              sample_valid_o,
  output logic                                 sweep_done_o,
  output logic                                 busy_o,
  output logic                                 overrun_o
);

  localparam int UPDATE_PERIOD = CLK_FREQ_HZ / UPDATE_FREQ_HZ;
  localparam int PER_W  = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int DIV_W  = $clog2(SCK_DIV);
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(UPDATE_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_DESELECT = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [PER_W-1:0]        per_q;
  logic [DIV_W-1:0]        div_q;
  logic [HALF_W-1:0]       half_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-2:0]   shift_q;
  logic [NUM_CHANNELS-1:0] valid_q;
  logic                    done_q;
  logic                    overrun_q;

  logic                    tick, div_end, half_last, idx_last, sel_active;
  logic                    sample_now, sample_last;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [RESULT_WIDTH-1:0] rx_result;
  logic                    unused_word;

  assign tick      = (per_q == '0) && enable_i;
  assign div_end   = (div_q == DIV_LAST);
  assign half_last = (half_q == HALF_LAST);
  assign idx_last  = (idx_q == IDX_LAST);
  assign rx_word   = {shift_q, miso_i};
  assign rx_result = rx_word[RESULT_WIDTH-1:0];
  assign unused_word = ^rx_word;

  // SCK is high in even half-periods; the sampling clk edge is the one that flips SCK.
  generate
    if (CPHA != 0) begin : g_cpha1
      assign sample_now  = (state_q == S_SHIFT) && div_end && !half_q[0];
      assign sample_last = sample_now && (half_q == HALF_W'(2 * DATA_WIDTH - 2));
    end else begin : g_cpha0
      assign sample_now  = div_end && ((state_q == S_SETUP) ||
                           ((state_q == S_SHIFT) && half_q[0] && !half_last));
      assign sample_last = sample_now && (state_q == S_SHIFT) &&
                           (half_q == HALF_W'(2 * DATA_WIDTH - 3));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (tick)                state_d = S_SETUP;
      S_SETUP:    if (div_end)             state_d = S_SHIFT;
      S_SHIFT:    if (div_end && half_last) state_d = S_HOLD;
      S_HOLD:     if (div_end)             state_d = S_DESELECT;
      S_DESELECT: if (div_end)             state_d = idx_last ? S_IDLE : S_SETUP;
      default:                             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ss_n_o     = '1;
    sck_o      = 1'b0;
    busy_o     = (state_q != S_IDLE);
    sel_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (sel_active && (idx_q == IDX_W'(k))) ss_n_o[k] = 1'b0;
    end
    if (state_q == S_SHIFT) sck_o = ~half_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      per_q     <= '0;
      div_q     <= '0;
      half_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      per_q   <= (per_q == '0) ? PER_LAST : per_q - PER_W'(1);
      valid_q <= '0;
      done_q  <= 1'b0;
      div_q   <= ((state_q == S_IDLE) || div_end) ? '0 : div_q + DIV_W'(1);
      if (state_q != S_SHIFT)  half_q <= '0;
      else if (div_end)        half_q <= half_q + HALF_W'(1);
      if (tick && (state_q != S_IDLE)) overrun_q <= 1'b1;
      if ((state_q == S_IDLE) && tick) idx_q <= '0;
      if ((state_q == S_DESELECT) && div_end) begin
        if (idx_last) done_q <= 1'b1;
        else          idx_q  <= idx_q + IDX_W'(1);
      end
      if (sample_now)  shift_q <= rx_word[DATA_WIDTH-2:0];
      if (sample_last) valid_q <= NUM_CHANNELS'(1) << idx_q;
    end
  end

  assign sample_valid_o = valid_q;
  assign sweep_done_o   = done_q;
  assign overrun_o      = overrun_q;

  generate
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
      logic                    hit;
      logic [RESULT_WIDTH-1:0] y_q;
      assign hit = sample_last && (idx_q == IDX_W'(k));
`ifdef CURRENT_SENSOR_FILTER_EN
      logic                           primed_q;
      logic signed [RESULT_WIDTH+1:0] diff, delta, sum;
      logic                           unused_sum;
      assign diff  = $signed({2'b00, rx_result}) - $signed({2'b00, y_q});
      assign delta = diff >>> 2;
      assign sum   = $signed({2'b00, y_q}) + delta;
      assign unused_sum = ^sum[RESULT_WIDTH+1:RESULT_WIDTH];
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          y_q      <= '0;
          primed_q <= 1'b0;
        end else if (hit) begin
          primed_q <= 1'b1;
          y_q      <= primed_q ? sum[RESULT_WIDTH-1:0] : rx_result;
        end
      end
`else
      always_ff @(posedge clk_i) begin
        if (reset_i)  y_q <= '0;
        else if (hit) y_q <= rx_result;
      end
`endif
      assign current_o[k*RESULT_WIDTH +: RESULT_WIDTH] = y_q;
    end
  endgenerate

endmodule
`default_nettype wire
